// File: rtl/vec_pkg.sv
// Shared constants, types and address helpers for the vector register file.
package vec_pkg;

  localparam int unsigned NUM_VREG = 8;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 128;

  typedef logic [ADDR_W-1:0] vreg_addr_t;
  typedef logic [DATA_W-1:0] vec_data_t;

  // True when the address names a physical register.
  function automatic logic vreg_in_range(input vreg_addr_t a);
    return 32'(a) < NUM_VREG;
  endfunction

  // One-hot decode of a register address; out-of-range decodes to all zeros.
  function automatic logic [NUM_VREG-1:0] vreg_onehot(input vreg_addr_t a);
    logic [NUM_VREG-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NUM_VREG); i++) begin
      if (a == ADDR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Scoreboard lookup; out-of-range addresses read as not busy.
  function automatic logic vreg_bit(input logic [NUM_VREG-1:0] v, input vreg_addr_t a);
    return |(v & vreg_onehot(a));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, first requester wins.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]                              req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]      ptr,
  output logic [N-1:0]                              grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]      grant_idx
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  // Rotating priority search starting at the pointer.
  always_comb begin
    logic found;
    int   j;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = int'(ptr) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (!found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = PTR_W'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_wb_scheduler.sv
// Write-port scheduler and RAW/WAW hazard scoreboard for the vector register file.
module vec_wb_scheduler
  import vec_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_rd,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic                       iss_valid,
  input  logic                       iss_wr,
  input  logic [ADDR_W-1:0]          iss_rd,
  input  logic [ADDR_W-1:0]          iss_rs1,
  input  logic [ADDR_W-1:0]          iss_rs2,
  output logic                       iss_stall,
  output logic [NUM_VREG-1:0]        busy,
  output logic                       err_addr
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  w_arb_gnt;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic                w_any;
  vreg_addr_t          w_sel_rd;
  vec_data_t           w_sel_data;
  logic                w_sel_ok;
  logic                r_rf_we;
  vreg_addr_t          r_rf_rd;
  vec_data_t           r_rf_wdata;
  logic [NUM_VREG-1:0] r_busy;
  logic [NUM_VREG-1:0] w_busy_nxt;
  logic                r_err;
  logic                w_stall;
  logic                w_fire;
  logic                w_iss_err;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_arb_gnt),
    .grant_idx (w_gnt_idx)
  );

  // No grants are handed out while reset is held.
  assign w_gnt     = rst ? '0 : w_arb_gnt;
  assign req_ready = w_gnt;
  assign w_any     = |w_gnt;

  // One-hot mux of the granted requester's address and data.
  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_gnt[i]) begin
        w_sel_rd   = w_sel_rd   | req_rd[i*ADDR_W +: ADDR_W];
        w_sel_data = w_sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_sel_ok = vreg_in_range(w_sel_rd);

  // Round-robin pointer advances past the winner on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end
  end

  // Registered write strobe; address/data hold when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_any & w_sel_ok;
      if (w_any && w_sel_ok) begin
        r_rf_rd    <= w_sel_rd;
        r_rf_wdata <= w_sel_data;
      end
    end
  end

  // Hazard check against pending writes; out-of-range sources never stall.
  assign w_stall = iss_valid & (vreg_bit(r_busy, iss_rs1) | vreg_bit(r_busy, iss_rs2) |
                                (iss_wr & vreg_bit(r_busy, iss_rd)));
  assign w_fire  = iss_valid & ~w_stall & iss_wr;

  assign w_iss_err = iss_valid & (~vreg_in_range(iss_rs1) | ~vreg_in_range(iss_rs2) |
                                  (iss_wr & ~vreg_in_range(iss_rd)));

  // Clear on completed write, then set on issue so a same-register set wins.
  assign w_busy_nxt = (r_busy & ~(r_rf_we ? vreg_onehot(r_rf_rd) : '0)) |
                      (w_fire ? vreg_onehot(iss_rd) : '0);

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // Sticky flag for any out-of-range write or issue address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if ((w_any && !w_sel_ok) || w_iss_err) r_err <= 1'b1;
  end

  assign rf_we     = r_rf_we;
  assign rf_rd     = r_rf_rd;
  assign rf_wdata  = r_rf_wdata;
  assign iss_stall = w_stall;
  assign busy      = r_busy;
  assign err_addr  = r_err;

endmodule

// File: tb/tb_vec_wb_scheduler.sv
// Directed self-checking bench for vec_wb_scheduler with hand-computed expectations.
module tb_vec_wb_scheduler;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [9:0]   req_rd;
  logic [255:0] req_data;
  logic         rf_we;
  logic [4:0]   rf_rd;
  logic [127:0] rf_wdata;
  logic         iss_valid;
  logic         iss_wr;
  logic [4:0]   iss_rd;
  logic [4:0]   iss_rs1;
  logic [4:0]   iss_rs2;
  logic         iss_stall;
  logic [7:0]   busy;
  logic         err_addr;

  int n_checks = 0;
  int n_errors = 0;

  vec_wb_scheduler #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .iss_valid (iss_valid),
    .iss_wr    (iss_wr),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .busy      (busy),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [4:0] rd, input logic [127:0] d);
    req_rd[idx*5 +: 5]       = rd;
    req_data[idx*128 +: 128] = d;
  endtask

  initial begin
    logic [127:0] exp_d;
    rst       = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_wr    = 1'b0;
    iss_rd    = '0;
    iss_rs1   = '0;
    iss_rs2   = '0;
    #1;
    check("rst_rf_we", 128'(rf_we), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(err_addr), 128'd0);
    tick();
    tick();
    rst = 1'b0;

    // Round-robin alternation between two always-valid requesters.
    req_valid = 2'b11;
    set_req(0, 5'd3, 128'h1000);
    set_req(1, 5'd5, 128'h2000);
    #1;
    check("rr_ready0", 128'(req_ready), 128'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_d = (k % 2 == 0) ? 128'h1000 + 128'(k) : 128'h2000 + 128'(k);
      check("rr_we", 128'(rf_we), 128'd1);
      check("rr_rd", 128'(rf_rd), (k % 2 == 0) ? 128'd3 : 128'd5);
      check("rr_wdata", rf_wdata, exp_d);
      set_req(0, 5'd3, 128'h1000 + 128'(k + 1));
      set_req(1, 5'd5, 128'h2000 + 128'(k + 1));
      if (k == 3) req_valid = 2'b00;
      #1;
      check("rr_ready", 128'(req_ready), (k == 3) ? 128'h0 : ((k % 2 == 0) ? 128'h2 : 128'h1));
    end
    tick();
    check("idle_we", 128'(rf_we), 128'd0);
    check("idle_rd_hold", 128'(rf_rd), 128'd5);
    check("idle_busy", 128'(busy), 128'd0);

    // RAW hazard on register 2 cleared by a writeback.
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd2; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    #1;
    check("raw_issue_nostall", 128'(iss_stall), 128'd0);
    tick();
    check("raw_busy_set", 128'(busy), 128'h04);
    iss_wr = 1'b0; iss_rs1 = 5'd2;
    req_valid = 2'b01;
    set_req(0, 5'd2, {16{8'hA5}});
    #1;
    check("raw_stall_N", 128'(iss_stall), 128'd1);
    check("raw_ready", 128'(req_ready), 128'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("raw_we", 128'(rf_we), 128'd1);
    check("raw_wrd", 128'(rf_rd), 128'd2);
    check("raw_wdata", rf_wdata, {16{8'hA5}});
    check("raw_stall_N1", 128'(iss_stall), 128'd1);
    tick();
    check("raw_stall_N2", 128'(iss_stall), 128'd0);
    check("raw_busy_clr", 128'(busy), 128'h00);
    iss_valid = 1'b0; iss_rs1 = 5'd0;

    // Set and clear of register 4 on the same edge: set wins.
    req_valid = 2'b10;
    set_req(1, 5'd4, 128'h44);
    #1;
    check("sw_ready1", 128'(req_ready), 128'h2);
    tick();
    req_valid = 2'b00;
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd4;
    #1;
    check("sw_we", 128'(rf_we), 128'd1);
    check("sw_nostall", 128'(iss_stall), 128'd0);
    tick();
    iss_valid = 1'b0; iss_wr = 1'b0;
    check("sw_busy4", 128'(busy), 128'h10);
    req_valid = 2'b01;
    set_req(0, 5'd4, 128'h45);
    tick();
    req_valid = 2'b00;
    tick();
    check("sw_busy_drain", 128'(busy), 128'h00);

    // WAW hazard on register 6.
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd6; iss_rs1 = 5'd0; iss_rs2 = 5'd1;
    tick();
    check("waw_busy6", 128'(busy), 128'h40);
    #1;
    check("waw_stall", 128'(iss_stall), 128'd1);
    iss_wr = 1'b0;
    #1;
    check("waw_nowr", 128'(iss_stall), 128'd0);
    iss_rs2 = 5'd6;
    #1;
    check("raw_rs2", 128'(iss_stall), 128'd1);
    iss_valid = 1'b0;
    #1;
    check("novalid", 128'(iss_stall), 128'd0);
    iss_rs2 = 5'd0;

    // Out-of-range writeback is accepted and dropped.
    req_valid = 2'b01;
    set_req(0, 5'd9, 128'h99);
    #1;
    check("oor_ready", 128'(req_ready), 128'h1);
    check("oor_err_pre", 128'(err_addr), 128'd0);
    tick();
    req_valid = 2'b00;
    #1;
    check("oor_we", 128'(rf_we), 128'd0);
    check("oor_err", 128'(err_addr), 128'd1);
    check("oor_rd_hold", 128'(rf_rd), 128'd4);
    tick();
    check("oor_sticky", 128'(err_addr), 128'd1);

    // Asynchronous reset mid-stream.
    req_valid = 2'b11;
    set_req(0, 5'd3, 128'h31);
    set_req(1, 5'd5, 128'h51);
    tick();
    check("pre_rst_we", 128'(rf_we), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 128'(req_ready), 128'h0);
    check("arst_we", 128'(rf_we), 128'd0);
    check("arst_rd", 128'(rf_rd), 128'd0);
    check("arst_busy", 128'(busy), 128'h00);
    check("arst_err", 128'(err_addr), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ptr", 128'(req_ready), 128'h1);
    req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
